fifo_wr_ctrl: RTL
=================

// Module: fifo_wr_ctrl
// PURPOSE
//   Write-side controller of the dual-clock FIFO. Owns the write pointer in the
//   write clock domain, gates memory writes, and derives full / almost-full /
//   fill-level flags from the read pointer delivered by the r2w synchronizer.
//   Exports its own Gray pointer to the w2r synchronizer on the read side.
// PARAMETERS
//   ASIZE      4            address width; FIFO depth = 2**ASIZE; ASIZE >= 2
//   AF_THRESH  2**ASIZE-2   wr_almost_full asserts when level >= AF_THRESH
// PORTS
//   wr_clk          in   1        write-domain clock
//   wr_rst          in   1        reset, asynchronous, active-high
//   wr_en           in   1        write request for the current cycle
//   r2w_ptr         in   ASIZE+1  read pointer (Gray), already 2-flop synced
//   ovf_clr         in   1        clears sticky wr_overflow
//   wr_ptr          out  ASIZE+1  write pointer (Gray), registered, to w2r sync
//   waddr           out  ASIZE    memory write address (binary pointer LSBs)
//   wclken          out  1        memory write enable = wr_en & ~wr_full
//   wr_full         out  1        FIFO full, registered
//   wr_almost_full  out  1        level >= AF_THRESH, registered
//   wr_count        out  ASIZE+1  fill level seen from write side, registered
//   wr_overflow     out  1        sticky: write attempted while full
// BEHAVIOUR
//   Reset (async assert, sync deassert by wr_clk edge): wbin=0, wr_ptr=0,
//     wr_full=0, wr_almost_full=0, wr_count=0, wr_overflow=0; waddr=0, wclken=0
//     while wr_rst high (wclken forced low during reset).
//   Pointer: binary wbin, ASIZE+1 bits, wraps modulo 2**(ASIZE+1).
//     wbin_nxt = wbin + wclken. wr_ptr <= (wbin_nxt>>1) ^ wbin_nxt.
//     waddr = wbin[ASIZE-1:0]; wclken combinational, same-cycle as wr_en.
//   Full: wr_full <= (gray(wbin_nxt) == {~r2w_ptr[ASIZE:ASIZE-1],
//     r2w_ptr[ASIZE-2:0]}). Asserts the cycle after the write filling the
//     last slot; no write is accepted while wr_full=1.
//   Level: rbin = gray2bin(r2w_ptr) (combinational XOR chain);
//     wr_count <= wbin_nxt - rbin (mod 2**(ASIZE+1)); range 0..2**ASIZE.
//     wr_almost_full <= (wbin_nxt - rbin) >= AF_THRESH.
//   All flags are pessimistic: r2w_ptr lags the true read pointer by 2+ cycles,
//     so full/count may overstate occupancy, never understate it.
//   Full release: r2w_ptr advance at edge N -> wr_full low after edge N+1.
//   Overflow: wr_en & wr_full -> no write, wbin unchanged, wr_overflow <= 1.
//     ovf_clr clears; set and ovf_clr same cycle -> set wins (stays 1).
//   Simultaneous write and r2w_ptr change: both folded into the same next-
//     state compare; no lost or duplicated pointer step.
//   Reset mid-operation: all state returns to reset values immediately; the
//     read domain must be reset in the same reset episode.
// TESTING
//   T1 reset: assert wr_rst mid-clock -> all outputs 0 without a clock edge.
//   T2 fill: ASIZE=4, r2w_ptr=0, 16 x wr_en -> waddr 0..15, wr_ptr=5'b11000,
//      wr_full=1 and wr_count=16 after 16th write; wr_almost_full=1 after 14th.
//   T3 overflow: when full, wr_en=1 -> wclken=0, wr_ptr held, wr_overflow=1;
//      ovf_clr with wr_en=1 while full -> wr_overflow stays 1; ovf_clr alone -> 0.
//   T4 release: full, set r2w_ptr=gray(3)=5'b00010 -> wr_full=0, wr_count=13
//      and wr_almost_full=0 one edge later; next write accepted at waddr 0.
//   T5 wrap: 40 writes with r2w_ptr tracking wbin-2 -> wr_ptr steps 5'b10000
//      (bin 31) -> 5'b00000, single-bit Gray change every step, wr_full never 1.
//   T6 reset mid-fill: 7 writes then wr_rst pulse -> wr_ptr=0, wr_count=0,
//      next write lands at waddr 0.

Source files
------------

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of a dual-clock FIFO: write pointer (binary + Gray),
// memory write gating, and pessimistic full / almost-full / level flags.
module fifo_wr_ctrl #(
    parameter int ASIZE     = 4,
    parameter int AF_THRESH = (1 << ASIZE) - 2
) (
    input  logic             wr_clk,
    input  logic             wr_rst,
    input  logic             wr_en,
    input  logic [ASIZE:0]   r2w_ptr,
    input  logic             ovf_clr,
    output logic [ASIZE:0]   wr_ptr,
    output logic [ASIZE-1:0] waddr,
    output logic             wclken,
    output logic             wr_full,
    output logic             wr_almost_full,
    output logic [ASIZE:0]   wr_count,
    output logic             wr_overflow
);

    localparam logic [ASIZE:0] AF_LEVEL = AF_THRESH[ASIZE:0];

    function automatic logic [ASIZE:0] bin2gray(input logic [ASIZE:0] b);
        return (b >> 1) ^ b;
    endfunction

    function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
        logic [ASIZE:0] b;
        b[ASIZE] = g[ASIZE];
        for (int i = ASIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [ASIZE:0] wbin_r;
    logic [ASIZE:0] wbin_nxt_s;
    logic [ASIZE:0] wgray_nxt_s;
    logic [ASIZE:0] rbin_s;
    logic [ASIZE:0] level_nxt_s;
    logic [ASIZE:0] full_gray_s;

    // Write gate: forced low while reset is held so nothing reaches memory.
    assign wclken = wr_en & ~wr_full & ~wr_rst;
    assign waddr  = wbin_r[ASIZE-1:0];

    // Next pointer and flag terms; the fresh write and the synced read pointer meet here.
    always_comb begin
        wbin_nxt_s  = wbin_r + {{ASIZE{1'b0}}, wclken};
        wgray_nxt_s = bin2gray(wbin_nxt_s);
        rbin_s      = gray2bin(r2w_ptr);
        level_nxt_s = wbin_nxt_s - rbin_s;
        full_gray_s = {~r2w_ptr[ASIZE:ASIZE-1], r2w_ptr[ASIZE-2:0]};
    end

    // Pointer, flag and sticky overflow registers.
    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            wbin_r         <= {(ASIZE+1){1'b0}};
            wr_ptr         <= {(ASIZE+1){1'b0}};
            wr_full        <= 1'b0;
            wr_almost_full <= 1'b0;
            wr_count       <= {(ASIZE+1){1'b0}};
            wr_overflow    <= 1'b0;
        end else begin
            wbin_r         <= wbin_nxt_s;
            wr_ptr         <= wgray_nxt_s;
            wr_full        <= (wgray_nxt_s == full_gray_s);
            wr_almost_full <= (level_nxt_s >= AF_LEVEL);
            wr_count       <= level_nxt_s;
            // A rejected write outranks a simultaneous clear.
            if (wr_en && wr_full) begin
                wr_overflow <= 1'b1;
            end else if (ovf_clr) begin
                wr_overflow <= 1'b0;
            end else begin
                wr_overflow <= wr_overflow;
            end
        end
    end

endmodule
